mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the IF-stage instruction fetch and the MEM-stage load/store port of the 5-stage pipelined CPU.
- Serialises accesses through a multi-cycle FSM and returns read data to the owning requester.
- Drives stall_if and stall_mem so the hazard logic freezes PC, IFID or EXMEM while a requester waits.
- Data port has fixed priority over fetch, because it serves the older instruction.

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data port
//
// Purpose:
//   Serialises IF-stage fetches and MEM-stage loads/stores onto one unified
//   single-ported memory. Data port has fixed priority (older instruction).
//   Each access runs IDLE -> ACCESS (WAIT_CYCLES cycles) -> RESP (one-cycle ack).
//
// Optional feature:
//   MEM_ARB_STARVE_GUARD_EN - after STARVE_LIMIT consecutive data grants made
//   while a fetch was waiting, the fetch wins the next contested arbitration.
//
// Ports:
//   clk, nreset            clock, asynchronous active-high reset
//   if_req/if_addr         fetch request (level) and byte address
//   if_rdata/if_ack        fetched instruction word, completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request, store flag, address, store data
//   dm_rdata/dm_ack        load data, completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory interface
//   stall_if/stall_mem     requester waiting (req & ~ack)
//   busy                   FSM not in IDLE
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("mem_port_arbiter: WAIT_CYCLES must be at least 1");
        end
        if (STARVE_LIMIT < 1) begin : g_bad_starve
            $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
        end
    endgenerate

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic              owner_dm;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant_dm;
    logic              grant_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic          starve_hit;

    // Contested arbitration only: a lone data request is never held back.
    assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT)) && if_req && dm_req;
    assign grant_dm   = dm_req && !starve_hit;
    assign grant_if   = if_req && !grant_dm;

    // Cannot pass STARVE_LIMIT: at the limit a waiting fetch takes the grant.
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            starve_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (grant_if) begin
                starve_cnt <= '0;
            end else if (grant_dm && if_req) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign grant_dm = dm_req;
    assign grant_if = if_req && !dm_req;
`endif

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            owner_dm <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_dm || grant_if) begin
                        state    <= S_ACCESS;
                        owner_dm <= grant_dm;
                        addr_q   <= grant_dm ? dm_addr : if_addr;
                        we_q     <= grant_dm && dm_we;
                        wdata_q  <= dm_wdata;
                        cnt      <= CW'(WAIT_CYCLES - 1);
                    end
                end
                S_ACCESS: begin
                    if (cnt == '0) begin
                        state <= S_RESP;
                        if (owner_dm) begin
                            if (!we_q) begin
                                dm_rdata <= mem_rdata;
                            end
                        end else begin
                            // Memory is 64 bits wide; bit 2 picks the instruction half.
                            if_rdata <= addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = (state == S_ACCESS);
    assign mem_we    = mem_en && owner_dm && we_q;
    assign mem_addr  = owner_dm ? addr_q : {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_wdata = wdata_q;
    assign if_ack    = (state == S_RESP) && !owner_dm;
    assign dm_ack    = (state == S_RESP) && owner_dm;
    assign stall_if  = if_req && !if_ack;
    assign stall_mem = dm_req && !dm_ack;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic [63:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        busy;

    // Second instance with single-cycle memory latency, fetch only.
    logic        if_req1 = 1'b0;
    logic [63:0] if_addr1 = '0;
    logic [31:0] if_rdata1;
    logic        if_ack1;
    logic [63:0] dm_rdata1;
    logic        dm_ack1;
    logic        mem_en1;
    logic        mem_we1;
    logic [63:0] mem_addr1;
    logic [63:0] mem_wdata1;
    logic        stall_if1;
    logic        stall_mem1;
    logic        busy1;
    logic [63:0] mem_rdata1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] memarr  [16];
    logic [63:0] ref_mem [16];
    logic [63:0] exp_dm;
    logic [31:0] exp_if;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .WAIT_CYCLES(W), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .nreset(nreset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .WAIT_CYCLES(1), .STARVE_LIMIT(4)) u_dut1 (
        .clk(clk), .nreset(nreset),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(64'd0), .dm_wdata(64'd0),
        .dm_rdata(dm_rdata1), .dm_ack(dm_ack1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1), .busy(busy1)
    );

    function automatic logic [63:0] init_word(input int i);
        return 64'hAABBCCDD_11223344 + 64'(i) * 64'h0001_0001_0001_0001;
    endfunction

    function automatic logic [31:0] half(input logic [63:0] w, input logic hi);
        return hi ? w[63:32] : w[31:0];
    endfunction

    // Memory model: reloaded while reset is held, written on store cycles.
    assign mem_rdata  = memarr[mem_addr[6:3]];
    assign mem_rdata1 = 64'hAABBCCDD_11223344;

    always @(posedge clk) begin
        if (nreset) begin
            for (int i = 0; i < 16; i++) memarr[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            memarr[mem_addr[6:3]] <= mem_wdata;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ref_init;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        exp_dm = '0;
        exp_if = '0;
    endtask

    // Drives one isolated transaction and reports what was observed.
    task automatic run_xact(input bit dm, input bit we, input logic [63:0] addr,
                            input logic [63:0] wd, output int lat, output int en_n,
                            output int we_n, output logic [63:0] seen_addr,
                            output bit stall_ok);
        bit got;
        if (dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        lat = 0; en_n = 0; we_n = 0; seen_addr = '1; stall_ok = 1'b1; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick;
            lat++;
            if (mem_en) begin en_n++; seen_addr = mem_addr; end
            if (mem_we) we_n++;
            if (dm ? dm_ack : if_ack) got = 1'b1;
            else if ((dm ? stall_mem : stall_if) !== 1'b1) stall_ok = 1'b0;
        end
        if (!got) lat = -1;
        dm_req = 1'b0; if_req = 1'b0; dm_we = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        nreset = 1'b1;
        if_req = 1'b0; dm_req = 1'b0;
        tick; tick;
        n_tests++;
        if ({busy, mem_en, mem_we, if_ack, dm_ack} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {busy, mem_en, mem_we, if_ack, dm_ack});
        end
        n_tests++;
        if (if_rdata !== 32'h0 || dm_rdata !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata: got if=%h dm=%h want 0", if_rdata, dm_rdata);
        end
        nreset = 1'b0;
        ref_init();
        tick;
        n_tests++;
        if (busy !== 1'b0 || stall_if !== 1'b0 || stall_mem !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b stalls=%b%b want 0", busy, stall_if, stall_mem);
        end
    endtask

    task automatic test_fetch;
        int lat, en_n, we_n; logic [63:0] sa; bit sok;
        run_xact(1'b0, 1'b0, 64'h4, 64'h0, lat, en_n, we_n, sa, sok);
        n_tests++;
        if (lat !== W + 1) begin n_fail++; $display("FAIL fetch_latency: got %0d want %0d", lat, W + 1); end
        n_tests++;
        if (en_n !== W || sa !== 64'h0) begin
            n_fail++; $display("FAIL fetch_mem: en_cycles=%0d addr=%h want %0d / 0", en_n, sa, W);
        end
        n_tests++;
        if (if_rdata !== 32'hAABBCCDD) begin n_fail++; $display("FAIL fetch_rdata: got %h want aabbccdd", if_rdata); end
        n_tests++;
        if (!sok) begin n_fail++; $display("FAIL fetch_stall: stall_if dropped before ack want 1"); end
        exp_if = 32'hAABBCCDD;
    endtask

    task automatic test_store_load;
        int lat, en_n, we_n; logic [63:0] sa; bit sok;
        run_xact(1'b1, 1'b1, 64'h10, 64'h5, lat, en_n, we_n, sa, sok);
        ref_mem[2] = 64'h5;
        n_tests++;
        if (lat !== W + 1 || we_n !== W || en_n !== W || !sok) begin
            n_fail++; $display("FAIL store: lat=%0d we=%0d en=%0d stall_ok=%0b want %0d/%0d/%0d/1", lat, we_n, en_n, sok, W + 1, W, W);
        end
        n_tests++;
        if (dm_rdata !== exp_dm) begin n_fail++; $display("FAIL store_rdata_hold: got %h want %h", dm_rdata, exp_dm); end
        run_xact(1'b1, 1'b0, 64'h10, 64'h0, lat, en_n, we_n, sa, sok);
        exp_dm = 64'h5;
        n_tests++;
        if (lat !== W + 1 || we_n !== 0 || !sok || sa !== 64'h10) begin
            n_fail++; $display("FAIL load: lat=%0d we=%0d stall_ok=%0b addr=%h want %0d/0/1/10", lat, we_n, sok, sa, W + 1);
        end
        n_tests++;
        if (dm_rdata !== 64'h5) begin n_fail++; $display("FAIL load_rdata: got %h want 5", dm_rdata); end
    endtask

    task automatic test_simultaneous;
        int t_dm, t_if; bit stall_ok, both;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h20;
        if_req = 1'b1; if_addr = 64'h8;
        t_dm = -1; t_if = -1; stall_ok = 1'b1; both = 1'b0;
        for (int t = 1; t <= 30 && t_if < 0; t++) begin
            tick;
            if (if_ack && dm_ack) both = 1'b1;
            if (dm_ack) begin t_dm = t; dm_req = 1'b0; end
            if (if_ack) begin t_if = t; if_req = 1'b0; end
            else if (stall_if !== 1'b1) stall_ok = 1'b0;
        end
        dm_req = 1'b0; if_req = 1'b0;
        tick;
        exp_dm = ref_mem[4];
        exp_if = half(ref_mem[1], 1'b0);
        n_tests++;
        if (t_dm !== W + 1) begin n_fail++; $display("FAIL simul_dm_first: dm_ack at %0d want %0d", t_dm, W + 1); end
        n_tests++;
        if (t_if !== t_dm + W + 2) begin n_fail++; $display("FAIL simul_if_after: if_ack at %0d want %0d", t_if, t_dm + W + 2); end
        n_tests++;
        if (!stall_ok || both) begin n_fail++; $display("FAIL simul_stall: stall_ok=%0b both_acks=%0b want 1/0", stall_ok, both); end
        n_tests++;
        if (dm_rdata !== exp_dm || if_rdata !== exp_if) begin
            n_fail++; $display("FAIL simul_rdata: dm=%h if=%h want %h %h", dm_rdata, if_rdata, exp_dm, exp_if);
        end
    endtask

    task automatic test_random;
        int lat, en_n, we_n, kind, idx; logic [63:0] sa, addr, wd; bit sok, hi;
        int bad = 0;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            idx  = $urandom_range(0, 15);
            hi   = 1'($urandom_range(0, 1));
            wd   = {$urandom, $urandom};
            addr = (kind == 0) ? 64'(idx * 8 + (hi ? 4 : 0)) : 64'(idx * 8);
            repeat ($urandom_range(0, 2)) tick;
            run_xact(kind != 0, kind == 2, addr, wd, lat, en_n, we_n, sa, sok);
            if (kind == 2) ref_mem[idx] = wd;
            else if (kind == 1) exp_dm = ref_mem[idx];
            else exp_if = half(ref_mem[idx], hi);
            n_tests++;
            if (lat !== W + 1 || en_n !== W || we_n !== ((kind == 2) ? W : 0) || sa !== 64'(idx * 8) || !sok) begin
                n_fail++; bad++;
                $display("FAIL rand_xact[%0d]: kind=%0d lat=%0d en=%0d we=%0d addr=%h stall_ok=%0b want lat=%0d addr=%h",
                         n, kind, lat, en_n, we_n, sa, sok, W + 1, idx * 8);
            end
            n_tests++;
            if (dm_rdata !== exp_dm || if_rdata !== exp_if) begin
                n_fail++; bad++;
                $display("FAIL rand_data[%0d]: dm=%h if=%h want %h %h", n, dm_rdata, if_rdata, exp_dm, exp_if);
            end
            if (bad > 8) break;
        end
    endtask

    task automatic test_reset_mid_access;
        bit ack_seen = 1'b0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h30; dm_wdata = 64'h77;
        tick; tick;
        n_tests++;
        if (mem_we !== 1'b1 || mem_en !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: mem_en=%b mem_we=%b want 1 1", mem_en, mem_we);
        end
        nreset = 1'b1;
        #1;
        n_tests++;
        if ({mem_we, mem_en, busy, dm_ack} !== 4'b0) begin
            n_fail++; $display("FAIL midrst_async: we/en/busy/ack=%b want 0000", {mem_we, mem_en, busy, dm_ack});
        end
        dm_req = 1'b0; dm_we = 1'b0;
        tick; tick;
        nreset = 1'b0;
        ref_init();
        for (int i = 0; i < 5; i++) begin
            tick;
            if (dm_ack || if_ack || busy) ack_seen = 1'b1;
        end
        n_tests++;
        if (ack_seen) begin n_fail++; $display("FAIL midrst_after: ack or busy seen=1 want 0"); end
    endtask

    task automatic test_starve_guard;
        int seq_n = 0, wrong = 0, if_cnt = 0; bit both = 1'b0; bit exp_fetch;
        nreset = 1'b1; tick; tick; nreset = 1'b0; ref_init();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h0;
        if_req = 1'b1; if_addr = 64'h8;
        for (int t = 0; t < 80 && seq_n < 10; t++) begin
            tick;
            if (dm_ack && if_ack) both = 1'b1;
            if (dm_ack || if_ack) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
                exp_fetch = (seq_n % 5) == 4;
`else
                exp_fetch = 1'b0;
`endif
                if (if_ack !== exp_fetch) wrong++;
                if (if_ack) if_cnt++;
                seq_n++;
            end
        end
        dm_req = 1'b0; if_req = 1'b0;
        tick; tick;
        n_tests++;
        if (seq_n !== 10 || wrong !== 0 || both) begin
            n_fail++; $display("FAIL starve_pattern: acks=%0d wrong_owner=%0d both=%0b want 10/0/0", seq_n, wrong, both);
        end
`ifndef MEM_ARB_STARVE_GUARD_EN
        n_tests++;
        if (if_cnt !== 0) begin n_fail++; $display("FAIL starve_off: if_acks=%0d want 0", if_cnt); end
`endif
    endtask

    task automatic test_back_to_back;
        int last_t = 0, acks = 0, bad_gap = 0, bad_data = 0;
        logic [63:0] w = 64'hAABBCCDD_11223344;
        if_req1 = 1'b1; if_addr1 = 64'h0;
        for (int t = 1; t <= 20 && acks < 3; t++) begin
            tick;
            if (if_ack1) begin
                if (t - last_t !== ((acks == 0) ? 2 : 3)) bad_gap++;
                if (if_rdata1 !== half(w, if_addr1[2])) bad_data++;
                last_t = t;
                acks++;
                if_addr1 = if_addr1 + 64'h4;
            end
        end
        if_req1 = 1'b0;
        tick;
        n_tests++;
        if (acks !== 3 || bad_gap !== 0) begin
            n_fail++; $display("FAIL b2b_timing: acks=%0d bad_gaps=%0d want 3/0", acks, bad_gap);
        end
        n_tests++;
        if (bad_data !== 0) begin n_fail++; $display("FAIL b2b_rdata: bad_words=%0d want 0", bad_data); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_simultaneous();
        test_random();
        test_reset_mid_access();
        test_starve_guard();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
